approx_err_monitor: RTL

//  Synthesizable on-chip error monitor for the 4x4 approximate multiplier. It consumes a

---
 rtl/approx_mult_pkg.sv | 17 +
 rtl/approx_err_divider.sv | 72 +++++++
 rtl/approx_err_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier error monitor:
// default widths and the monitor FSM state encoding.
package approx_mult_pkg;

  localparam int W_DEF     = 4;
  localparam int P_W_DEF   = 2 * W_DEF;
  localparam int FRAC_DEF  = 8;
  localparam int CNT_W_DEF = 16;
  localparam int ACC_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_ACC  = 2'd2
  } mon_state_e;

endpackage : approx_mult_pkg

// File: rtl/approx_err_divider.sv
// Sequential restoring divider: one quotient bit per clock, 2W+FRAC steps.
// A start pulse loads numerator/divisor; done_o is high during the cycle whose
// closing edge retires the last quotient bit, so quo_o is final after that edge.
import approx_mult_pkg::*;

module approx_err_divider #(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2*W+FRAC-1:0]   num_i,
  input  logic [2*W-1:0]        den_i,
  output logic                  done_o,
  output logic [2*W+FRAC-1:0]   quo_o
);

  localparam int PW = 2 * W;
  localparam int NW = PW + FRAC;
  localparam int CW = $clog2(NW + 1);

  logic [PW-1:0] rem_q;
  logic [PW-1:0] den_q;
  logic [NW-1:0] shf_q;   // remaining numerator bits shift out, quotient bits shift in
  logic [CW-1:0] cnt_q;

  logic [PW:0]   trial_s;
  logic [PW:0]   diff_s;
  logic          ge_s;
  logic [PW-1:0] rem_d;

  // One restoring step: bring down the next numerator bit and try a subtract.
  always_comb begin
    trial_s = {rem_q, shf_q[NW-1]};
    diff_s  = trial_s - {1'b0, den_q};
    ge_s    = (trial_s >= {1'b0, den_q});
    if (ge_s) begin
      rem_d = diff_s[PW-1:0];
    end else begin
      rem_d = trial_s[PW-1:0];
    end
  end

  // Load on start, otherwise step while bits remain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      den_q <= '0;
      shf_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      den_q <= den_i;
      shf_q <= num_i;
      cnt_q <= CW'(NW);
    end else if (cnt_q != CW'(0)) begin
      rem_q <= rem_d;
      shf_q <= {shf_q[NW-2:0], ge_s};
      cnt_q <= cnt_q - CW'(1);
    end else begin
      rem_q <= rem_q;
      den_q <= den_q;
      shf_q <= shf_q;
      cnt_q <= cnt_q;
    end
  end

  assign done_o = (cnt_q == CW'(1));
  assign quo_o  = shf_q;

endmodule : approx_err_divider

// File: rtl/approx_err_monitor.sv
// Error monitor for the approximate multiplier: accepts (a, b, approx_p) samples,
// recomputes the exact product and accumulates saturating error statistics.
import approx_mult_pkg::*;

module approx_err_monitor #(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stat_clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [2*W-1:0]     in_p,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   nz_cnt,
  output logic [ACC_W-1:0]   abs_err_sum,
  output logic [ACC_W-1:0]   rel_err_sum,
  output logic [2*W-1:0]     max_abs_err,
  output logic               sat
);

  localparam int PW = 2 * W;
  localparam int NW = PW + FRAC;
  // Sum width wide enough for either accumulator operand plus a carry.
  localparam int SW = ((ACC_W > NW) ? ACC_W : NW) + 1;
  localparam logic [SW-1:0] ACC_MAX = (SW'(1) << ACC_W) - SW'(1);

  mon_state_e      state_q;
  logic            ready_q;
  logic [PW-1:0]   exact_q;
  logic [PW-1:0]   err_q;
  logic [CNT_W-1:0] sample_cnt_q, nz_cnt_q;
  logic [ACC_W-1:0] abs_sum_q, rel_sum_q;
  logic [PW-1:0]   max_err_q;
  logic            sat_q;

  logic [PW-1:0]   exact_s;
  logic [PW-1:0]   err_s;
  logic            hs_s;
  logic            div_start_s;
  logic            div_done_s;
  logic [NW-1:0]   quo_s;

  logic [CNT_W:0]  cnt_sum_s, nz_sum_s;
  logic [SW-1:0]   abs_sum_s, rel_sum_s;
  logic            cnt_ovf_s, nz_ovf_s, abs_ovf_s, rel_ovf_s;
  logic [CNT_W-1:0] sample_cnt_d, nz_cnt_d;
  logic [ACC_W-1:0] abs_sum_d, rel_sum_d;
  logic [PW-1:0]   max_err_d;
  logic            sat_d;

  // A clear in the same cycle blocks acceptance.
  assign in_ready    = ready_q & ~stat_clear;
  assign hs_s        = in_valid & in_ready;
  assign div_start_s = hs_s & (exact_s != '0);

  // Exact product and unsigned absolute error of the incoming sample.
  always_comb begin
    exact_s = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
    if (in_p >= exact_s) begin
      err_s = in_p - exact_s;
    end else begin
      err_s = exact_s - in_p;
    end
  end

  approx_err_divider #(
    .W    (W),
    .FRAC (FRAC)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start_s),
    .num_i   ({err_s, {FRAC{1'b0}}}),
    .den_i   (exact_s),
    .done_o  (div_done_s),
    .quo_o   (quo_s)
  );

  // Saturating next values of every statistic for the latched sample.
  always_comb begin
    cnt_sum_s = {1'b0, sample_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    nz_sum_s  = {1'b0, nz_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    abs_sum_s = SW'(abs_sum_q) + SW'(err_q);
    rel_sum_s = SW'(rel_sum_q) + SW'(quo_s);
    cnt_ovf_s = cnt_sum_s[CNT_W];
    nz_ovf_s  = nz_sum_s[CNT_W] & (exact_q != '0);
    abs_ovf_s = (abs_sum_s > ACC_MAX);
    rel_ovf_s = (rel_sum_s > ACC_MAX) & (exact_q != '0);

    sample_cnt_d = cnt_ovf_s ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];
    abs_sum_d    = abs_ovf_s ? {ACC_W{1'b1}} : abs_sum_s[ACC_W-1:0];
    if (exact_q != '0) begin
      nz_cnt_d  = nz_sum_s[CNT_W] ? {CNT_W{1'b1}} : nz_sum_s[CNT_W-1:0];
      rel_sum_d = rel_ovf_s ? {ACC_W{1'b1}} : rel_sum_s[ACC_W-1:0];
    end else begin
      nz_cnt_d  = nz_cnt_q;
      rel_sum_d = rel_sum_q;
    end
    if (err_q > max_err_q) begin
      max_err_d = err_q;
    end else begin
      max_err_d = max_err_q;
    end
    sat_d = sat_q | cnt_ovf_s | nz_ovf_s | abs_ovf_s | rel_ovf_s;
  end

  // Control FSM with registered ready and statistics; clear overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      exact_q      <= '0;
      err_q        <= '0;
      sample_cnt_q <= '0;
      nz_cnt_q     <= '0;
      abs_sum_q    <= '0;
      rel_sum_q    <= '0;
      max_err_q    <= '0;
      sat_q        <= 1'b0;
    end else if (stat_clear) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      sample_cnt_q <= '0;
      nz_cnt_q     <= '0;
      abs_sum_q    <= '0;
      rel_sum_q    <= '0;
      max_err_q    <= '0;
      sat_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs_s) begin
            exact_q <= exact_s;
            err_q   <= err_s;
            ready_q <= 1'b0;
            state_q <= (exact_s == '0) ? ST_ACC : ST_DIV;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_DIV: begin
          ready_q <= 1'b0;
          if (div_done_s) begin
            state_q <= ST_ACC;
          end else begin
            state_q <= ST_DIV;
          end
        end
        ST_ACC: begin
          sample_cnt_q <= sample_cnt_d;
          nz_cnt_q     <= nz_cnt_d;
          abs_sum_q    <= abs_sum_d;
          rel_sum_q    <= rel_sum_d;
          max_err_q    <= max_err_d;
          sat_q        <= sat_d;
          ready_q      <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sample_cnt  = sample_cnt_q;
  assign nz_cnt      = nz_cnt_q;
  assign abs_err_sum = abs_sum_q;
  assign rel_err_sum = rel_sum_q;
  assign max_abs_err = max_err_q;
  assign sat         = sat_q;

endmodule : approx_err_monitor
